// File: rtl/matrix_result_streamer_pkg.sv
// rtl/matrix_result_streamer_pkg.sv - shared constants, state encoding and element offset helper
package matrix_result_streamer_pkg;

    localparam int MAT_DIM = 3;
    localparam int ELEM_W  = 8;
    localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;
    localparam logic [1:0] IDX_MAX = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (row,col) inside the concatenated matrix bus.
    function automatic logic [6:0] elem_offset(input logic [1:0] row, input logic [1:0] col);
        return 7'(ELEM_W * (MAT_DIM * int'(row) + int'(col)));
    endfunction

endpackage

// File: rtl/matrix_result_streamer_idx_counter.sv
// rtl/matrix_result_streamer_idx_counter.sv - 0..2 enable counter with synchronous clear and wrap flag
module stream_idx_counter
    import matrix_result_streamer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] count,
    output logic       wrap
);

    // Wrap is qualified by enable so it can directly enable the next counter in the chain.
    assign wrap = en && (count == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
        end else if (clr) begin
            count <= 2'd0;
        end else if (en) begin
            count <= wrap ? 2'd0 : count + 2'd1;
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - streams a captured 3x3 result matrix element by element; MATRIX_STREAM_TRANSPOSE_EN selects column-major order
module matrix_result_streamer #(
    parameter int DIM    = 3,
    parameter int ELEM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIM*DIM*ELEM_W-1:0] matrix_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_data,
    output logic [1:0]                out_row,
    output logic [1:0]                out_col,
    output logic                      out_last,
    output logic                      done
);
    import matrix_result_streamer_pkg::*;

    state_t                    state;
    logic [DIM*DIM*ELEM_W-1:0] shadow;
    logic [1:0]                row;
    logic [1:0]                col;
    logic                      xfer;
    logic                      at_last;
    logic                      step;
    logic                      clr;
    logic                      inner_wrap;
    logic                      unused_outer_wrap;

    assign xfer    = out_valid && out_ready;
    assign at_last = (row == IDX_MAX) && (col == IDX_MAX);
    // Indices freeze on the final element so they still read (2,2) during DONE.
    assign step    = xfer && !at_last;
    assign clr     = (state == IDLE) && start;

`ifdef MATRIX_STREAM_TRANSPOSE_EN
    stream_idx_counter u_inner (
        .clk(clk), .rst(rst), .clr(clr), .en(step),
        .count(row), .wrap(inner_wrap)
    );
    stream_idx_counter u_outer (
        .clk(clk), .rst(rst), .clr(clr), .en(inner_wrap),
        .count(col), .wrap(unused_outer_wrap)
    );
`else
    stream_idx_counter u_inner (
        .clk(clk), .rst(rst), .clr(clr), .en(step),
        .count(col), .wrap(inner_wrap)
    );
    stream_idx_counter u_outer (
        .clk(clk), .rst(rst), .clr(clr), .en(inner_wrap),
        .count(row), .wrap(unused_outer_wrap)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow    <= matrix_in;
                        state     <= SEND;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer && at_last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = shadow[elem_offset(row, col) +: ELEM_W];
    assign out_row  = row;
    assign out_col  = col;
    assign out_last = out_valid && at_last;

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Reader-side companion to the 3x3 matrix multiplier datapath.
- Captures the finished 72-bit concatenated result matrix on a start pulse.
- Streams the nine 8-bit elements out one per handshake over a valid/ready interface, tagged with row/col.
- Sits between the multiplier's concatenated result bus and any downstream consumer (UART, display, checker).

Parameters:
DIM, 3, matrix dimension (rows = cols = DIM); only 3 is supported.
ELEM_W, 8, result element width in bits.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: matrix_in is valid, begin streaming
matrix_in  input  DIM*DIM*ELEM_W (72)  concatenated result matrix; element (r,c) occupies bits [8*(3r+c)+7 : 8*(3r+c)]
busy  output  1  high from the cycle after an accepted start through the DONE cycle
out_valid  output  1  out_data/out_row/out_col/out_last are valid
out_ready  input  1  consumer accepts the current element
out_data  output  ELEM_W  current element value
out_row  output  2  row index of current element, 0..2
out_col  output  2  column index of current element, 0..2
out_last  output  1  current element is the final one of the matrix
done  output  1  one-cycle pulse after the final element transfers

Behaviour:
- Reset (asynchronous, any state): state=IDLE; shadow register=0; row=col=0. Outputs busy, out_valid, out_data, out_row, out_col, out_last and done all read 0.
- States are IDLE, SEND and DONE.
- IDLE:
  - start=1 captures matrix_in into the shadow register, clears the row/col counters and moves to SEND.
  - Latency: start in cycle N gives out_valid=1 with element (0,0) in cycle N+1.
- SEND:
  - out_valid=1; out_data = shadow element (row,col); out_last = (row==2 && col==2).
  - A transfer occurs on a rising edge with out_valid && out_ready.
  - On transfer with col<2: col++.
  - On transfer with col==2 and row<2: col=0, row++ (row-major order).
  - On transfer with out_last: go to DONE; row/col hold.
  - out_ready=0 stalls. All output fields stay stable; there is no timeout.
- DONE:
  - done=1 and out_valid=0 for exactly one cycle, then IDLE.
- start while busy (SEND or DONE) is ignored. The shadow register is not overwritten.
- start in the same cycle as the DONE→IDLE transition is ignored. It is accepted only while in IDLE.
- Throughput: with out_ready held high, nine elements stream in nine consecutive cycles. A new matrix can start no sooner than 2 cycles after the last transfer.
- matrix_in may change freely after the start cycle. Only the captured copy is streamed.
- Counters wrap 2→0 only under the rules above. Values 3 are never produced.

Optional Feature:
- Macro: MATRIX_STREAM_TRANSPOSE_EN.
- Defined: streaming order is column-major, i.e. row increments first. The sequence is (0,0),(1,0),(2,0),(0,1),… ,(2,2). out_row/out_col still report the true element indices, and out_last is still asserted on (2,2).
- Undefined: row-major order as above.
- Latency, handshake and done timing are identical in both builds.

Decomposition:
- Shared package holds:
  - constants MAT_DIM=3, ELEM_W=8, MAT_W=72, IDX_MAX=2;
  - state encoding IDLE=2'd0, SEND=2'd1, DONE=2'd2;
  - a function mapping (row,col) to bit offset 8*(3*row+col).
- One natural sub-module, stream_idx_counter: a 2-bit enable counter that counts 0..2 and wraps to 0. It has async active-high reset and a synchronous clear, and outputs a wrap flag. It is instantiated twice, for row and col, with the wrap flag chaining the inner counter to the outer.

Test Plan:
- Reset mid-stream: start, transfer 4 elements, assert rst → same cycle busy=0, out_valid=0, out_row=out_col=0. After release, start a new matrix → stream restarts at (0,0).
- Basic row-major stream: matrix_in element i = i+1 (bytes 0x01..0x09), start pulse, out_ready=1 → out_data 0x01..0x09 on cycles N+1..N+9. out_last only with 0x09 at (2,2); done=1 at N+10; busy=0 at N+11.
- Backpressure: same matrix, out_ready low for 3 cycles while (1,1)=0x05 is presented → out_data=0x05, out_row=1, out_col=1 held stable. Resumes with 0x06 after the first ready-high edge.
- Capture isolation: start with matrix X, then drive matrix_in=all 0xFF and pulse start during SEND → all nine streamed values match X. The second start is ignored, and exactly one done pulse occurs.
- Max values: every element 0xFF (matrix_in all ones), random out_ready → nine transfers of 0xFF, row/col never 3, one done.
- MATRIX_STREAM_TRANSPOSE_EN build, elements i+1 → sequence 0x01,0x04,0x07,0x02,0x05,0x08,0x03,0x06,0x09 with matching (row,col) tags. out_last is on 0x09.
